pitch_tone_sequencer: RTL and testbench

Plays fixed-length tones on the PWM audio generator for the pitch-training flow. Arbitrates between two requesters: prompt tones from the lesson controller (port A) and feedback beeps from the scoring logic (port B). Each accepted request drives the generator's 3-bit frequency select and amplifier enable for a programmed number of milliseconds, followed by a silent inter-tone gap. Sits between the control FSMs and the PWM audio block.

---
 rtl/pitch_tone_sequencer_if.sv | 22 ++
 rtl/pitch_tone_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pitch_tone_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pitch_tone_sequencer_if.sv
// Request handshake between the tone requesters (lesson controller on A,
// scoring logic on B) and the tone sequencer.
interface pitch_tone_sequencer_if;
  logic        a_valid;
  logic [2:0]  a_frq;
  logic [11:0] a_dur;
  logic        a_ready;
  logic        b_valid;
  logic [2:0]  b_frq;
  logic [11:0] b_dur;
  logic        b_ready;

  modport master (
    output a_valid, a_frq, a_dur, b_valid, b_frq, b_dur,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_frq, a_dur, b_valid, b_frq, b_dur,
    output a_ready, b_ready
  );
endinterface

// File: rtl/pitch_tone_sequencer.sv
// Two-port tone sequencer: B beats A, each grant plays frq for dur ms on the
// PWM audio generator, then holds a silent gap of GAP_MS ms.
module pitch_tone_sequencer #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_DIV = 100_000,
  parameter int GAP_MS   = 20
) (
  input  logic                         clock,
  input  logic                         resetn,
  pitch_tone_sequencer_if.slave        req,
  input  logic                         abort,
  output logic [2:0]                   frq,
  output logic                         SD,
  output logic                         busy,
  output logic                         owner,
  output logic                         done_a,
  output logic                         done_b,
  output logic                         aborted
);

  localparam int                DIV_W     = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [11:0]       GAP_TICKS = 12'(GAP_MS);

  if (TICK_DIV < 2 || CLK_HZ < TICK_DIV) begin : g_bad_params
    $error("pitch_tone_sequencer: TICK_DIV must be >= 2 and <= CLK_HZ");
  end

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  state_e             state_q, state_d;
  logic [2:0]         frq_q, frq_d;
  logic               owner_q, owner_d;
  logic               sd_q, sd_d;
  logic               busy_q, busy_d;
  logic [11:0]        ms_left_q, ms_left_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               done_a_q, done_a_d;
  logic               done_b_q, done_b_d;
  logic               aborted_q, aborted_d;

  logic               accept_a, accept_b;
  logic [2:0]         sel_frq;
  logic [11:0]        sel_dur;
  logic               tick;
  logic               finish;

  assign req.b_ready = (state_q == IDLE) && !abort;
  assign req.a_ready = (state_q == IDLE) && !abort && !req.b_valid;

  assign accept_b = req.b_valid && req.b_ready;
  assign accept_a = req.a_valid && req.a_ready;
  assign sel_frq  = accept_b ? req.b_frq : req.a_frq;
  assign sel_dur  = accept_b ? req.b_dur : req.a_dur;
  assign tick     = (div_q == DIV_LAST);

  // NOTE: every *_d gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d   = state_q;
    frq_d     = frq_q;
    owner_d   = owner_q;
    sd_d      = sd_q;
    busy_d    = busy_q;
    ms_left_d = ms_left_q;
    div_d     = div_q;
    done_a_d  = 1'b0;
    done_b_d  = 1'b0;
    aborted_d = 1'b0;
    finish    = 1'b0;

    if (state_q != IDLE && abort) begin
      state_d   = IDLE;
      sd_d      = 1'b0;
      busy_d    = 1'b0;
      aborted_d = 1'b1;
      ms_left_d = '0;
      div_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_a || accept_b) begin
            owner_d   = accept_b;
            frq_d     = sel_frq;
            ms_left_d = sel_dur;
            div_d     = '0;
            if (sel_dur != '0) begin
              state_d = PLAY;
              sd_d    = 1'b1;
              busy_d  = 1'b1;
            end else begin
              done_a_d = !accept_b;
              done_b_d = accept_b;
            end
          end
        end
        PLAY, GAP: begin
          if (tick) begin
            div_d     = '0;
            ms_left_d = ms_left_q - 12'd1;
            if (ms_left_q == 12'd1) begin
              sd_d = 1'b0;
              // A finished tone enters the gap with the gap length reloaded.
              if (state_q == PLAY && GAP_MS > 0) begin
                state_d   = GAP;
                ms_left_d = GAP_TICKS;
              end else begin
                finish = 1'b1;
              end
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (finish) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_a_d = !owner_q;
      done_b_d = owner_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the same pre-edge *_d values. All flops here are control, so all reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      frq_q     <= '0;
      owner_q   <= 1'b0;
      sd_q      <= 1'b0;
      busy_q    <= 1'b0;
      ms_left_q <= '0;
      div_q     <= '0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frq_q     <= frq_d;
      owner_q   <= owner_d;
      sd_q      <= sd_d;
      busy_q    <= busy_d;
      ms_left_q <= ms_left_d;
      div_q     <= div_d;
      done_a_q  <= done_a_d;
      done_b_q  <= done_b_d;
      aborted_q <= aborted_d;
    end
  end

  assign frq     = frq_q;
  assign SD      = sd_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
  assign done_a  = done_a_q;
  assign done_b  = done_b_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_pitch_tone_sequencer.sv
// Directed bench for pitch_tone_sequencer with TICK_DIV = 10, GAP_MS = 2:
// tone 1 ms = 10 cycles, gap = 20 cycles.
module tb_pitch_tone_sequencer;
  localparam int TICK_DIV = 10;
  localparam int GAP_MS   = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] frq;
  logic       sd, busy, owner, done_a, done_b, aborted;

  int tests_run = 0;
  int tests_failed = 0;

  pitch_tone_sequencer_if req_if ();

  pitch_tone_sequencer #(
    .CLK_HZ  (100_000_000),
    .TICK_DIV(TICK_DIV),
    .GAP_MS  (GAP_MS)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .req    (req_if),
    .abort  (abort),
    .frq    (frq),
    .SD     (sd),
    .busy   (busy),
    .owner  (owner),
    .done_a (done_a),
    .done_b (done_b),
    .aborted(aborted)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_if.a_valid = 1'b0;
    req_if.a_frq   = '0;
    req_if.a_dur   = '0;
    req_if.b_valid = 1'b0;
    req_if.b_frq   = '0;
    req_if.b_dur   = '0;
    abort          = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({frq, sd, busy, owner, done_a, done_b, aborted} !== 9'b0) begin
      $display("FAIL reset_outputs: got %b required 000000000",
               {frq, sd, busy, owner, done_a, done_b, aborted});
      tests_failed++;
    end
    resetn = 1'b1;
    step();
    tests_run++;
    if (req_if.a_ready !== 1'b1 || req_if.b_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_release: got a_ready=%b b_ready=%b busy=%b required 1 1 0",
               req_if.a_ready, req_if.b_ready, busy);
      tests_failed++;
    end
  endtask

  // Scenario 1: A plays frq 3 for 5 ms, then the gap, then done_a.
  task automatic test_single_tone(input string tag);
    int n;
    int bad;
    req_if.a_valid = 1'b1;
    req_if.a_frq   = 3'd3;
    req_if.a_dur   = 12'd5;
    #1;
    tests_run++;
    if (req_if.a_ready !== 1'b1) begin
      $display("FAIL %s_a_ready: got %b required 1", tag, req_if.a_ready);
      tests_failed++;
    end
    step();
    req_if.a_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || owner !== 1'b0) begin
      $display("FAIL %s_grant: got busy=%b owner=%b required 1 0", tag, busy, owner);
      tests_failed++;
    end
    n = 0;
    bad = 0;
    while (sd === 1'b1 && n < 5000) begin
      if (frq !== 3'd3) bad++;
      n++;
      step();
    end
    tests_run++;
    if (n != 50 || bad != 0) begin
      $display("FAIL %s_sd_len: got %0d cycles (%0d bad frq) required 50 (0)", tag, n, bad);
      tests_failed++;
    end
    n = 0;
    bad = 0;
    while (busy === 1'b1 && n < 5000) begin
      if (sd !== 1'b0 || frq !== 3'd3 || done_a !== 1'b0) bad++;
      n++;
      step();
    end
    tests_run++;
    if (n != 20 || bad != 0) begin
      $display("FAIL %s_gap_len: got %0d cycles (%0d bad) required 20 (0)", tag, n, bad);
      tests_failed++;
    end
    tests_run++;
    if (done_a !== 1'b1 || done_b !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL %s_done: got done_a=%b done_b=%b busy=%b required 1 0 0",
               tag, done_a, done_b, busy);
      tests_failed++;
    end
    step();
    tests_run++;
    if (done_a !== 1'b0) begin
      $display("FAIL %s_done_width: got done_a=%b required 0", tag, done_a);
      tests_failed++;
    end
  endtask

  // Scenario 2: simultaneous requests, B wins, A accepted on done_b cycle.
  task automatic test_priority();
    int n;
    req_if.a_valid = 1'b1;
    req_if.a_frq   = 3'd5;
    req_if.a_dur   = 12'd1;
    req_if.b_valid = 1'b1;
    req_if.b_frq   = 3'd1;
    req_if.b_dur   = 12'd2;
    #1;
    tests_run++;
    if (req_if.a_ready !== 1'b0 || req_if.b_ready !== 1'b1) begin
      $display("FAIL prio_ready: got a_ready=%b b_ready=%b required 0 1",
               req_if.a_ready, req_if.b_ready);
      tests_failed++;
    end
    step();
    req_if.b_valid = 1'b0;
    tests_run++;
    if (owner !== 1'b1 || frq !== 3'd1 || sd !== 1'b1) begin
      $display("FAIL prio_grant: got owner=%b frq=%0d sd=%b required 1 1 1", owner, frq, sd);
      tests_failed++;
    end
    n = 0;
    while (sd === 1'b1 && n < 5000) begin
      n++;
      step();
    end
    tests_run++;
    if (n != 20) begin
      $display("FAIL prio_b_len: got %0d cycles required 20", n);
      tests_failed++;
    end
    n = 0;
    while (done_b !== 1'b1 && n < 100) begin
      n++;
      step();
    end
    tests_run++;
    if (done_b !== 1'b1 || n != 20 || req_if.a_ready !== 1'b1) begin
      $display("FAIL prio_done_b: got done_b=%b after %0d gap cycles a_ready=%b required 1 20 1",
               done_b, n, req_if.a_ready);
      tests_failed++;
    end
    step();
    req_if.a_valid = 1'b0;
    tests_run++;
    if (owner !== 1'b0 || frq !== 3'd5 || sd !== 1'b1) begin
      $display("FAIL prio_a_after_b: got owner=%b frq=%0d sd=%b required 0 5 1", owner, frq, sd);
      tests_failed++;
    end
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin
      n++;
      step();
    end
    tests_run++;
    if (n != 30) begin
      $display("FAIL prio_a_total: got %0d cycles to done_a required 30", n);
      tests_failed++;
    end
    step();
  endtask

  // Scenario 3: zero-duration request completes without sounding.
  task automatic test_zero_dur();
    req_if.b_valid = 1'b1;
    req_if.b_frq   = 3'd6;
    req_if.b_dur   = 12'd0;
    #1;
    tests_run++;
    if (req_if.b_ready !== 1'b1) begin
      $display("FAIL zero_b_ready: got %b required 1", req_if.b_ready);
      tests_failed++;
    end
    step();
    req_if.b_valid = 1'b0;
    tests_run++;
    if (done_b !== 1'b1 || sd !== 1'b0 || busy !== 1'b0 || frq !== 3'd6 || owner !== 1'b1) begin
      $display("FAIL zero_done: got done_b=%b sd=%b busy=%b frq=%0d owner=%b required 1 0 0 6 1",
               done_b, sd, busy, frq, owner);
      tests_failed++;
    end
    step();
    tests_run++;
    if (done_b !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL zero_after: got done_b=%b busy=%b required 0 0", done_b, busy);
      tests_failed++;
    end
  endtask

  // Scenario 4: abort in PLAY, abort in GAP, abort while idle.
  task automatic test_abort();
    int stray;
    req_if.a_valid = 1'b1;
    req_if.a_frq   = 3'd2;
    req_if.a_dur   = 12'd4;
    step();
    req_if.a_valid = 1'b0;
    repeat (6) step();
    abort = 1'b1;
    step();
    tests_run++;
    if (sd !== 1'b0 || busy !== 1'b0 || aborted !== 1'b1 || done_a !== 1'b0) begin
      $display("FAIL abort_play: got sd=%b busy=%b aborted=%b done_a=%b required 0 0 1 0",
               sd, busy, aborted, done_a);
      tests_failed++;
    end
    abort = 1'b0;
    #1;
    tests_run++;
    if (req_if.a_ready !== 1'b1) begin
      $display("FAIL abort_reaccept_ready: got a_ready=%b required 1", req_if.a_ready);
      tests_failed++;
    end
    stray = 0;
    repeat (60) begin
      step();
      if (done_a !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      $display("FAIL abort_play_quiet: got %0d stray cycles required 0", stray);
      tests_failed++;
    end

    req_if.a_valid = 1'b1;
    req_if.a_dur   = 12'd1;
    step();
    req_if.a_valid = 1'b0;
    repeat (15) step();
    tests_run++;
    if (sd !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL abort_in_gap_pre: got sd=%b busy=%b required 0 1", sd, busy);
      tests_failed++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests_run++;
    if (sd !== 1'b0 || busy !== 1'b0 || aborted !== 1'b1 || done_a !== 1'b0) begin
      $display("FAIL abort_gap: got sd=%b busy=%b aborted=%b done_a=%b required 0 0 1 0",
               sd, busy, aborted, done_a);
      tests_failed++;
    end
    stray = 0;
    repeat (30) begin
      step();
      if (done_a !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      $display("FAIL abort_gap_quiet: got %0d stray cycles required 0", stray);
      tests_failed++;
    end

    abort = 1'b1;
    req_if.a_valid = 1'b1;
    req_if.a_dur   = 12'd3;
    #1;
    tests_run++;
    if (req_if.a_ready !== 1'b0 || req_if.b_ready !== 1'b0) begin
      $display("FAIL abort_idle_ready: got a_ready=%b b_ready=%b required 0 0",
               req_if.a_ready, req_if.b_ready);
      tests_failed++;
    end
    step();
    req_if.a_valid = 1'b0;
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || aborted !== 1'b0 || sd !== 1'b0) begin
      $display("FAIL abort_idle: got busy=%b aborted=%b sd=%b required 0 0 0", busy, aborted, sd);
      tests_failed++;
    end
  endtask

  // Scenario 5: asynchronous reset in the middle of a tone.
  task automatic test_reset_mid_tone();
    req_if.a_valid = 1'b1;
    req_if.a_frq   = 3'd4;
    req_if.a_dur   = 12'd3;
    step();
    req_if.a_valid = 1'b0;
    repeat (5) step();
    tests_run++;
    if (sd !== 1'b1 || frq !== 3'd4) begin
      $display("FAIL rst_pre: got sd=%b frq=%0d required 1 4", sd, frq);
      tests_failed++;
    end
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (sd !== 1'b0 || busy !== 1'b0 || frq !== 3'd0 || owner !== 1'b0) begin
      $display("FAIL rst_async: got sd=%b busy=%b frq=%0d owner=%b required 0 0 0 0",
               sd, busy, frq, owner);
      tests_failed++;
    end
    step();
    resetn = 1'b1;
    step();
    tests_run++;
    if (done_a !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL rst_no_pulse: got done_a=%b aborted=%b busy=%b required 0 0 0",
               done_a, aborted, busy);
      tests_failed++;
    end
    test_single_tone("post_rst");
  endtask

  // Scenario 6: B held valid keeps winning over A, tone after tone.
  task automatic test_back_to_back();
    int n;
    int a_hi;
    a_hi = 0;
    req_if.a_valid = 1'b1;
    req_if.a_frq   = 3'd2;
    req_if.a_dur   = 12'd2;
    req_if.b_valid = 1'b1;
    req_if.b_frq   = 3'd7;
    req_if.b_dur   = 12'd1;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (req_if.b_ready !== 1'b1) begin
        $display("FAIL b2b_b_ready_%0d: got %b required 1", k, req_if.b_ready);
        tests_failed++;
      end
      if (req_if.a_ready !== 1'b0) a_hi++;
      step();
      n = 0;
      while (sd === 1'b1 && n < 5000) begin
        if (req_if.a_ready !== 1'b0) a_hi++;
        n++;
        step();
      end
      tests_run++;
      if (n != 10) begin
        $display("FAIL b2b_len_%0d: got %0d cycles required 10", k, n);
        tests_failed++;
      end
      n = 0;
      while (busy === 1'b1 && n < 5000) begin
        if (req_if.a_ready !== 1'b0) a_hi++;
        n++;
        step();
      end
      tests_run++;
      if (n != 20 || done_b !== 1'b1 || owner !== 1'b1 || frq !== 3'd7) begin
        $display("FAIL b2b_gap_%0d: got gap=%0d done_b=%b owner=%b frq=%0d required 20 1 1 7",
                 k, n, done_b, owner, frq);
        tests_failed++;
      end
      if (req_if.a_ready !== 1'b0) a_hi++;
    end
    req_if.a_valid = 1'b0;
    req_if.b_valid = 1'b0;
    step();
    tests_run++;
    if (a_hi != 0 || busy !== 1'b0) begin
      $display("FAIL b2b_a_starved: got a_ready high %0d cycles busy=%b required 0 0", a_hi, busy);
      tests_failed++;
    end
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    test_reset();
    test_single_tone("single");
    test_priority();
    test_zero_dur();
    test_abort();
    test_reset_mid_tone();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
